imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the instruction memory. Receives a byte stream
//  through a valid/ready handshake and packs it little-endian into 32-bit
//  instruction words. Drives the memory's write port at word-aligned byte
//  addresses (memory indexes by A[31:2]).
//  Holds the core in reset (cpu_hold) while a program image loads, then releases it.
// PARAMETERS
//  DEPTH      64  number of instruction words in the target memory
//  BASE_ADDR  0   byte address of the first word written (multiple of 4)
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   one-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  in_valid    in   1   in_data holds a byte
//  in_data     in   8   image byte, least significant byte of each word first
//  in_last     in   1   qualifies the final byte of the image
//  in_ready    out  1   loader accepts a byte this cycle
//  wr_en       out  1   one-cycle write strobe to the instruction memory
//  wr_addr     out  32  byte address, always BASE_ADDR + 4*word_idx
//  wr_data     out  32  assembled instruction word
//  cpu_hold    out  1   keep processor in reset; high in LOAD and WRITE
//  done        out  1   level, high in DONE
//  err         out  1   sticky until next start: partial last word or overflow
//  word_count  out  7   words written in current or last load ($clog2(DEPTH)+1)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state IDLE. All outputs are 0.
//    Byte counter and word index are 0. Memory contents are untouched.
//  - Transfer occurs when in_valid & in_ready. in_ready=1 only in LOAD.
//  - FSM states: IDLE, LOAD, WRITE, DONE.
//  - IDLE/DONE + start -> LOAD. Clear byte_cnt, word_idx, word_count, err, done.
//  - LOAD, byte transfer: the byte goes to word[8*byte_cnt +: 8] and byte_cnt increments.
//    - byte_cnt==3: -> WRITE.
//    - in_last with byte_cnt<3: partial word is discarded, no write. err=1, -> DONE.
//  - WRITE (exactly one cycle):
//    - wr_en=1, wr_addr=BASE_ADDR+{word_idx,2'b00}, wr_data=word, in_ready=0.
//    - Then word_idx++, word_count++, byte_cnt=0.
//    - in_last was on the 4th byte: -> DONE, err unchanged.
//    - Else word_idx+1==DEPTH: memory full, err=1, -> DONE.
//    - Else -> LOAD.
//  - Latency: the write strobe comes 1 cycle after the 4th byte transfers.
//    Peak throughput is 4 bytes per 5 cycles.
//  - wr_addr/wr_data are registered and hold their last values outside WRITE.
//    wr_en is the only write qualifier.
//  - DONE: done=1, cpu_hold=0, in_ready=0. Bytes arriving here are not consumed.
//  - start in LOAD/WRITE is ignored. in_last without in_valid is ignored.
//  - Reset mid-load: immediate return to IDLE. cpu_hold drops. Words already
//    written stay in memory. The next start begins again at BASE_ADDR.
//  - Arithmetic: word_idx is $clog2(DEPTH) bits and never wraps.
//    The full check happens before the increment.
// STRUCTURE
//  - Shared package/include: FSM state encodings, WORD_BYTES=4, BYTE_W=8,
//    and the IMEM_DEPTH default shared with the instruction memory.
//  - One sub-module, word_packer: byte_cnt plus shift-in of bytes into a
//    32-bit word, with a full flag.
//  - The FSM and the address/count logic stay in imem_loader.
// TESTING
//  1. Normal load
//     - Stimulus: start, then bytes 13 01 50 00 93 01 C0 00, in_last on the 8th.
//     - Required: writes (0x0,0x00500113) and (0x4,0x00C00193).
//       Then done=1, word_count=2, err=0, cpu_hold=0.
//  2. Backpressure
//     - Stimulus: in_valid held high continuously.
//     - Required: in_ready=0 during each WRITE cycle, and that byte is retained
//       and accepted next cycle. No byte is lost or duplicated.
//  3. Partial last word
//     - Stimulus: in_last on the 6th byte.
//     - Required: exactly one write (addr 0x0), err=1, done=1, word_count=1.
//  4. Overflow
//     - Stimulus: DEPTH=4, BASE_ADDR=0x40, five words with no in_last.
//     - Required: writes to 0x40,0x44,0x48,0x4C, then err=1, done=1,
//       and the 17th byte is not accepted.
//  5. Reset mid-load
//     - Stimulus: rst_n low after 2 bytes.
//     - Required: all outputs 0 with no wr_en. A new start and 4 bytes give
//       a write at BASE_ADDR.
//  6. start ignored, then restart
//     - Stimulus: start pulsed in LOAD, then start pulsed in DONE.
//     - Required: the pulse in LOAD has no effect. The pulse in DONE clears
//       done/err/word_count and sets cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, byte/word geometry
// and the default memory depth used by the instruction memory itself.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int BCNT_W     = $clog2(WORD_BYTES);
    localparam int IMEM_DEPTH = 64;

    // Byte address of a word slot: the memory indexes by A[31:2].
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: tracks the byte position and exposes the word as it
// will look once the offered byte is merged, so the completed word can be captured directly.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              full
);

    logic [BCNT_W-1:0] byte_cnt_r;
    logic [WORD_W-1:0] word_r;

    assign full = (byte_cnt_r == BCNT_W'(WORD_BYTES - 1));

    // Merge the offered byte into its lane of the partially assembled word.
    always_comb begin
        word_next = word_r;
        word_next[BYTE_W*byte_cnt_r +: BYTE_W] = byte_in;
    end

    // Byte counter wraps to zero after the last lane, ready for the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r <= '0;
            word_r     <= '0;
        end else if (clr) begin
            byte_cnt_r <= '0;
            word_r     <= '0;
        end else if (shift_en) begin
            byte_cnt_r <= byte_cnt_r + BCNT_W'(1'b1);
            word_r     <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into the instruction memory one 32-bit word at a time and keeps
// the core held in reset until the image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [31:0]              wr_addr,
    output logic [31:0]              wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_t              state_r;
    state_t              next_state_s;
    logic                xfer_s;
    logic                clr_s;
    logic                err_set_s;
    logic                last_r;
    logic                full_s;
    logic                mem_full_s;
    logic [WORD_W-1:0]   word_next_s;
    logic [IDX_W-1:0]    word_idx_r;

    assign xfer_s     = in_valid && (state_r == ST_LOAD);
    assign mem_full_s = (({1'b0, word_idx_r} + CNT_W'(1'b1)) == CNT_W'(DEPTH));

    word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .shift_en  (xfer_s),
        .byte_in   (in_data),
        .word_next (word_next_s),
        .full      (full_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic plus the load-clear and error-set strobes.
    always_comb begin
        next_state_s = state_r;
        clr_s        = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                    clr_s        = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s && full_s) begin
                    next_state_s = ST_WRITE;
                end else if (xfer_s && in_last) begin
                    next_state_s = ST_DONE;
                    err_set_s    = 1'b1;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (last_r) begin
                    next_state_s = ST_DONE;
                end else if (mem_full_s) begin
                    next_state_s = ST_DONE;
                    err_set_s    = 1'b1;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
        end else begin
            in_ready <= (next_state_s == ST_LOAD);
            cpu_hold <= (next_state_s == ST_LOAD) || (next_state_s == ST_WRITE);
            done     <= (next_state_s == ST_DONE);
            wr_en    <= (next_state_s == ST_WRITE);
        end
    end

    // Word capture, address generation and load bookkeeping; the word index saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= 32'h0000_0000;
            wr_data    <= 32'h0000_0000;
            word_idx_r <= '0;
            word_count <= '0;
            err        <= 1'b0;
            last_r     <= 1'b0;
        end else if (clr_s) begin
            word_idx_r <= '0;
            word_count <= '0;
            err        <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            if (xfer_s && full_s) begin
                wr_addr <= word_addr(BASE_ADDR, 32'(word_idx_r));
                wr_data <= word_next_s;
                last_r  <= in_last;
            end
            if (state_r == ST_WRITE) begin
                word_count <= word_count + CNT_W'(1'b1);
                if (!mem_full_s) begin
                    word_idx_r <= word_idx_r + IDX_W'(1'b1);
                end
            end
            if (err_set_s) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance (64 words at 0x0) and a small
// instance (4 words at 0x40) for the memory-full case.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1, v0, v1;
    logic [7:0]  in_data;
    logic        in_last;

    logic        rdy0, wen0, hold0, done0, err0;
    logic [31:0] wa0, wd0;
    logic [6:0]  wc0;
    logic        rdy1, wen1, hold1, done1, err1;
    logic [31:0] wa1, wd1;
    logic [2:0]  wc1;

    int errors = 0;
    int checks = 0;
    int nw0 = 0;
    int nw1 = 0;
    int stall, stall_wr;
    logic [31:0] wa_log0 [0:31];
    logic [31:0] wd_log0 [0:31];
    logic [31:0] wa_log1 [0:31];
    logic [31:0] wd_log1 [0:31];
    logic [7:0]  bytes [0:31];

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(v0), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy0), .wr_en(wen0), .wr_addr(wa0), .wr_data(wd0),
        .cpu_hold(hold0), .done(done0), .err(err0), .word_count(wc0)
    );

    imem_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0040)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(v1), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy1), .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1),
        .cpu_hold(hold1), .done(done1), .err(err1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    // Record every write strobe of both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (wen0) begin
            if (nw0 < 32) begin wa_log0[nw0] = wa0; wd_log0[nw0] = wd0; end
            nw0 = nw0 + 1;
        end
        if (wen1) begin
            if (nw1 < 32) begin wa_log1[nw1] = wa1; wd_log1[nw1] = wd1; end
            nw1 = nw1 + 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    // Hold in_valid high and advance through bytes[first..n-1] as they are accepted.
    task automatic stream(input int sel, input int first, input int n, input int last_at);
        int  i;
        int  cyc;
        logic rdy;
        i = first; cyc = 0;
        while (i < n && cyc < 200) begin
            in_data = bytes[i];
            in_last = (i == last_at);
            if (sel == 0) v0 = 1'b1; else v1 = 1'b1;
            @(negedge clk);
            rdy = (sel == 0) ? rdy0 : rdy1;
            if (rdy) begin
                i++;
            end else begin
                stall++;
                if ((sel == 0) ? wen0 : wen1) stall_wr++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        v0 = 1'b0; v1 = 1'b0; in_last = 1'b0;
        checks++;
        if (i !== n) begin errors++; $display("FAIL stream_accept: accepted up to %0d, required %0d", i, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        @(negedge clk);
        checks++; if ({rdy0, wen0, hold0, done0, err0} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b required 00000", {rdy0, wen0, hold0, done0, err0}); end
        checks++; if (wa0 !== 32'h0 || wd0 !== 32'h0) begin errors++; $display("FAIL reset_wr: got %h/%h required 0/0", wa0, wd0); end
        checks++; if (wc0 !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", wc0); end
        checks++; if ({rdy1, wen1, hold1, done1, err1, wc1} !== 8'b0) begin errors++; $display("FAIL reset_small: got %b required 0", {rdy1, wen1, hold1, done1, err1, wc1}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_normal();
        int base;
        base = nw0;
        bytes[0] = 8'h13; bytes[1] = 8'h01; bytes[2] = 8'h50; bytes[3] = 8'h00;
        bytes[4] = 8'h93; bytes[5] = 8'h01; bytes[6] = 8'hC0; bytes[7] = 8'h00;
        pulse_start(0);
        @(negedge clk);
        checks++; if ({hold0, rdy0, done0} !== 3'b110) begin errors++; $display("FAIL normal_load_state: got %b required 110", {hold0, rdy0, done0}); end
        @(posedge clk); #1;
        stream(0, 0, 8, 7);
        cycles(3);
        @(negedge clk);
        checks++; if (nw0 - base !== 2) begin errors++; $display("FAIL normal_nwrites: got %0d required 2", nw0 - base); end
        checks++; if (wa_log0[base] !== 32'h0 || wd_log0[base] !== 32'h00500113) begin errors++; $display("FAIL normal_w0: got %h/%h required 00000000/00500113", wa_log0[base], wd_log0[base]); end
        checks++; if (wa_log0[base+1] !== 32'h4 || wd_log0[base+1] !== 32'h00C00193) begin errors++; $display("FAIL normal_w1: got %h/%h required 00000004/00c00193", wa_log0[base+1], wd_log0[base+1]); end
        checks++; if ({done0, err0, hold0, rdy0} !== 4'b1000) begin errors++; $display("FAIL normal_done: got %b required 1000", {done0, err0, hold0, rdy0}); end
        checks++; if (wc0 !== 7'd2) begin errors++; $display("FAIL normal_count: got %0d required 2", wc0); end
    endtask

    task automatic test_backpressure();
        int base;
        base = nw0;
        for (int i = 0; i < 12; i++) bytes[i] = 8'(8'h10 + i);
        stall = 0; stall_wr = 0;
        pulse_start(0);
        stream(0, 0, 12, 11);
        cycles(3);
        @(negedge clk);
        checks++; if (stall !== 2 || stall_wr !== 2) begin errors++; $display("FAIL bp_stalls: got %0d stalls (%0d in write) required 2 (2)", stall, stall_wr); end
        checks++; if (nw0 - base !== 3) begin errors++; $display("FAIL bp_nwrites: got %0d required 3", nw0 - base); end
        checks++; if (wd_log0[base] !== 32'h13121110 || wd_log0[base+1] !== 32'h17161514 || wd_log0[base+2] !== 32'h1B1A1918)
            begin errors++; $display("FAIL bp_data: got %h %h %h required 13121110 17161514 1b1a1918", wd_log0[base], wd_log0[base+1], wd_log0[base+2]); end
        checks++; if (wa_log0[base+2] !== 32'h8) begin errors++; $display("FAIL bp_addr: got %h required 00000008", wa_log0[base+2]); end
        checks++; if ({done0, err0, wc0} !== {1'b1, 1'b0, 7'd3}) begin errors++; $display("FAIL bp_status: got done=%b err=%b count=%0d required 1 0 3", done0, err0, wc0); end
    endtask

    task automatic test_partial();
        int base;
        base = nw0;
        for (int i = 0; i < 6; i++) bytes[i] = 8'(8'hA0 + i);
        pulse_start(0);
        stream(0, 0, 6, 5);
        cycles(3);
        @(negedge clk);
        checks++; if (nw0 - base !== 1) begin errors++; $display("FAIL partial_nwrites: got %0d required 1", nw0 - base); end
        checks++; if (wa_log0[base] !== 32'h0 || wd_log0[base] !== 32'hA3A2A1A0) begin errors++; $display("FAIL partial_w0: got %h/%h required 00000000/a3a2a1a0", wa_log0[base], wd_log0[base]); end
        checks++; if ({done0, err0, wc0} !== {1'b1, 1'b1, 7'd1}) begin errors++; $display("FAIL partial_status: got done=%b err=%b count=%0d required 1 1 1", done0, err0, wc0); end
    endtask

    task automatic test_overflow();
        int base;
        int took;
        base = nw1;
        took = 0;
        for (int i = 0; i < 17; i++) bytes[i] = 8'(8'h20 + i);
        pulse_start(1);
        stream(1, 0, 16, -1);
        in_data = bytes[16];
        v1 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rdy1) took++;
            @(posedge clk); #1;
        end
        v1 = 1'b0;
        @(negedge clk);
        checks++; if (took !== 0) begin errors++; $display("FAIL ovf_17th: in_ready high %0d cycles, required 0", took); end
        checks++; if (nw1 - base !== 4) begin errors++; $display("FAIL ovf_nwrites: got %0d required 4", nw1 - base); end
        checks++; if (wa_log1[base] !== 32'h40 || wa_log1[base+1] !== 32'h44 || wa_log1[base+2] !== 32'h48 || wa_log1[base+3] !== 32'h4C)
            begin errors++; $display("FAIL ovf_addr: got %h %h %h %h required 40 44 48 4c", wa_log1[base], wa_log1[base+1], wa_log1[base+2], wa_log1[base+3]); end
        checks++; if (wd_log1[base] !== 32'h23222120 || wd_log1[base+3] !== 32'h2F2E2D2C) begin errors++; $display("FAIL ovf_data: got %h %h required 23222120 2f2e2d2c", wd_log1[base], wd_log1[base+3]); end
        checks++; if ({done1, err1, hold1, wc1} !== {1'b1, 1'b1, 1'b0, 3'd4}) begin errors++; $display("FAIL ovf_status: got done=%b err=%b hold=%b count=%0d required 1 1 0 4", done1, err1, hold1, wc1); end
    endtask

    task automatic test_start_ignored();
        int base;
        base = nw0;
        for (int i = 0; i < 6; i++) bytes[i] = 8'(8'hC0 + i);
        pulse_start(0);
        stream(0, 0, 2, -1);
        pulse_start(0);
        stream(0, 2, 6, 5);
        cycles(3);
        @(negedge clk);
        checks++; if (nw0 - base !== 1 || wa_log0[base] !== 32'h0 || wd_log0[base] !== 32'hC3C2C1C0)
            begin errors++; $display("FAIL ign_write: got %0d writes, %h/%h required 1, 00000000/c3c2c1c0", nw0 - base, wa_log0[base], wd_log0[base]); end
        checks++; if ({done0, err0, wc0} !== {1'b1, 1'b1, 7'd1}) begin errors++; $display("FAIL ign_status: got done=%b err=%b count=%0d required 1 1 1", done0, err0, wc0); end
        pulse_start(0);
        @(negedge clk);
        checks++; if ({done0, err0, wc0, hold0, rdy0} !== {1'b0, 1'b0, 7'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL restart_clear: got done=%b err=%b count=%0d hold=%b rdy=%b required 0 0 0 1 1", done0, err0, wc0, hold0, rdy0); end
        @(posedge clk); #1;
        base = nw0;
        for (int i = 0; i < 4; i++) bytes[i] = 8'(8'hD0 + i);
        stream(0, 0, 4, 3);
        cycles(3);
        @(negedge clk);
        checks++; if (nw0 - base !== 1 || wa_log0[base] !== 32'h0 || wd_log0[base] !== 32'hD3D2D1D0 || done0 !== 1'b1)
            begin errors++; $display("FAIL restart_write: got %0d writes, %h/%h done=%b required 1, 00000000/d3d2d1d0 1", nw0 - base, wa_log0[base], wd_log0[base], done0); end
    endtask

    task automatic test_reset_midload();
        int base;
        for (int i = 0; i < 4; i++) bytes[i] = 8'(8'hE0 + i);
        pulse_start(0);
        stream(0, 0, 2, -1);
        rst_n = 1'b0;
        base = nw0;
        @(negedge clk);
        checks++; if ({rdy0, wen0, hold0, done0, err0} !== 5'b0 || wc0 !== 7'd0 || wa0 !== 32'h0 || wd0 !== 32'h0)
            begin errors++; $display("FAIL midrst_outputs: got flags=%b count=%0d addr=%h data=%h required all 0", {rdy0, wen0, hold0, done0, err0}, wc0, wa0, wd0); end
        cycles(2);
        checks++; if (nw0 !== base) begin errors++; $display("FAIL midrst_nowrite: got %0d writes required 0", nw0 - base); end
        rst_n = 1'b1;
        cycles(1);
        pulse_start(0);
        stream(0, 0, 4, 3);
        cycles(3);
        @(negedge clk);
        checks++; if (nw0 - base !== 1 || wa_log0[base] !== 32'h0 || wd_log0[base] !== 32'hE3E2E1E0)
            begin errors++; $display("FAIL midrst_rewrite: got %0d writes, %h/%h required 1, 00000000/e3e2e1e0", nw0 - base, wa_log0[base], wd_log0[base]); end
        checks++; if ({done0, err0, wc0} !== {1'b1, 1'b0, 7'd1}) begin errors++; $display("FAIL midrst_status: got done=%b err=%b count=%0d required 1 0 1", done0, err0, wc0); end
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        in_data = 8'h00; in_last = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_partial();
        test_overflow();
        test_start_ignored();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
